vga_genlock: RTL and testbench



---
 rtl/vga_genlock.sv | 169 ++++++++++++++++
 tb/tb_vga_genlock.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/vga_genlock.sv
// Genlock front end for the VGA timing generator: measures an external reference vsync period,
// locks onto it and emits a delayed one-cycle genlock pulse after each qualified reference edge.
module vga_genlock #(
  parameter logic [19:0] MIN_PERIOD   = 20'd300000,
  parameter logic [19:0] MAX_PERIOD   = 20'd370000,
  parameter logic [2:0]  LOCK_COUNT   = 3'd4,
  parameter logic [1:0]  UNLOCK_COUNT = 2'd2
) (
  input  logic        clk,
  input  logic        srst,
  input  logic        enable,
  input  logic        ref_vsync,
  input  logic [19:0] offset,
  output logic        genlock,
  output logic        locked,
  output logic [19:0] period,
  output logic        timeout
);

  typedef enum logic [1:0] {StIdle, StSearch, StLocking, StLocked} state_e;

  state_e      state_q, state_d;
  logic        s1_q, s2_q, s3_q;
  logic        ref_edge;
  logic [19:0] pcnt_q, pcnt_d, pcnt_inc;
  logic [19:0] period_q, period_d;
  logic [19:0] dcnt_q, dcnt_d;
  logic [2:0]  good_q, good_d, good_inc;
  logic [1:0]  miss_q, miss_d, miss_inc;
  logic        pending_q, pending_d;
  logic        locked_q, timeout_q, timeout_d;
  logic        good_period, to_cond, arm, cancel;

  assign ref_edge    = s2_q & ~s3_q;
  assign pcnt_inc    = pcnt_q + 20'd1;
  assign good_inc    = good_q + 3'd1;
  assign miss_inc    = miss_q + 2'd1;
  assign good_period = (pcnt_inc >= MIN_PERIOD) && (pcnt_inc <= MAX_PERIOD);
  // An edge landing on the would-be timeout cycle is treated as an edge.
  assign to_cond     = !ref_edge && (pcnt_q == MAX_PERIOD) &&
                       ((state_q == StLocking) || (state_q == StLocked));

  always_comb begin
    state_d   = state_q;
    good_d    = good_q;
    miss_d    = miss_q;
    arm       = 1'b0;
    cancel    = 1'b0;
    timeout_d = 1'b0;
    if (!enable) begin
      state_d = StIdle;
      cancel  = 1'b1;
    end else begin
      unique case (state_q)
        StIdle: state_d = StSearch;
        StSearch: begin
          if (ref_edge) begin
            state_d = StLocking;
            good_d  = 3'd0;
          end
        end
        StLocking: begin
          if (ref_edge) begin
            if (good_period) begin
              good_d = good_inc;
              if (good_inc == LOCK_COUNT) begin
                state_d = StLocked;
                miss_d  = 2'd0;
                arm     = 1'b1;
              end
            end else begin
              good_d = 3'd0;
            end
          end else if (to_cond) begin
            state_d   = StSearch;
            timeout_d = 1'b1;
          end
        end
        StLocked: begin
          if (ref_edge) begin
            if (good_period) begin
              miss_d = 2'd0;
              arm    = 1'b1;
            end else begin
              miss_d = miss_inc;
              cancel = 1'b1;
              if (miss_inc == UNLOCK_COUNT) begin
                state_d = StLocking;
                good_d  = 3'd0;
              end
            end
          end else if (to_cond) begin
            state_d   = StSearch;
            cancel    = 1'b1;
            timeout_d = 1'b1;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_comb begin
    pcnt_d = pcnt_q;
    if ((state_q == StIdle) || ref_edge) begin
      pcnt_d = 20'd0;
    end else if (pcnt_q != MAX_PERIOD + 20'd1) begin
      pcnt_d = pcnt_inc;
    end
    period_d = period_q;
    if (ref_edge && enable && (state_q != StIdle)) begin
      period_d = pcnt_inc;
    end
  end

  // Single outstanding pulse: arming always overrides whatever was pending.
  always_comb begin
    dcnt_d    = dcnt_q;
    pending_d = pending_q;
    if (arm) begin
      dcnt_d    = offset;
      pending_d = 1'b1;
    end else if (cancel) begin
      pending_d = 1'b0;
    end else if (pending_q) begin
      if (dcnt_q == 20'd0) begin
        pending_d = 1'b0;
      end else begin
        dcnt_d = dcnt_q - 20'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      state_q   <= StIdle;
      s1_q      <= 1'b0;
      s2_q      <= 1'b0;
      s3_q      <= 1'b0;
      pcnt_q    <= 20'd0;
      period_q  <= 20'd0;
      dcnt_q    <= 20'd0;
      good_q    <= 3'd0;
      miss_q    <= 2'd0;
      pending_q <= 1'b0;
      locked_q  <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      s1_q      <= ref_vsync;
      s2_q      <= s1_q;
      s3_q      <= s2_q;
      pcnt_q    <= pcnt_d;
      period_q  <= period_d;
      dcnt_q    <= dcnt_d;
      good_q    <= good_d;
      miss_q    <= miss_d;
      pending_q <= pending_d;
      locked_q  <= (state_d == StLocked);
      timeout_q <= timeout_d;
    end
  end

  assign genlock = pending_q && (dcnt_q == 20'd0);
  assign locked  = locked_q;
  assign period  = period_q;
  assign timeout = timeout_q;

endmodule

// File: tb/tb_vga_genlock.sv
// Bench for vga_genlock with periods scaled down 1000x (nominal frame 332 clk).
module tb_vga_genlock;

  logic        clk = 1'b0;
  logic        srst, enable, ref_vsync;
  logic [19:0] offset;
  logic        genlock, locked, timeout;
  logic [19:0] period;

  vga_genlock #(
    .MIN_PERIOD  (20'd300),
    .MAX_PERIOD  (20'd370),
    .LOCK_COUNT  (3'd4),
    .UNLOCK_COUNT(2'd2)
  ) dut (
    .clk      (clk),
    .srst     (srst),
    .enable   (enable),
    .ref_vsync(ref_vsync),
    .offset   (offset),
    .genlock  (genlock),
    .locked   (locked),
    .period   (period),
    .timeout  (timeout)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;
  int gl_q[$];
  int to_q[$];
  int prev_rise;

  typedef struct {
    int gap;
    int off;
    bit pulse;
    bit lck;
    int per;
  } vec_t;

  vec_t vt [33];

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Edge cycle is rise+2; a pulse is due at rise+3+offset; locked/period settle at rise+3.
  task automatic run_row(input vec_t v);
    int tgt;
    tgt = prev_rise + v.gap;
    while (cyc < tgt) step();
    offset    = 20'(v.off);
    ref_vsync = 1'b1;
    prev_rise = cyc;
    if (v.pulse) gl_q.push_back(cyc + 3 + v.off);
    while (cyc < prev_rise + 3) step();
    chk("locked", int'(locked), int'(v.lck));
    if (v.per != 0) chk("period", int'(period), v.per);
    while (cyc < prev_rise + 10) step();
    ref_vsync = 1'b0;
  endtask

  task automatic run_rows(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) run_row(vt[i]);
  endtask

  always @(negedge clk) begin
    if (gl_q.size() != 0 && gl_q[0] < cyc) begin
      chk("genlock_missed", cyc, gl_q[0]);
      void'(gl_q.pop_front());
    end
    if (genlock === 1'b1) begin
      if (gl_q.size() == 0) chk("genlock_unexpected", 1, 0);
      else chk("genlock_cycle", cyc, gl_q.pop_front());
    end
    if (to_q.size() != 0 && to_q[0] < cyc) begin
      chk("timeout_missed", cyc, to_q[0]);
      void'(to_q.pop_front());
    end
    if (timeout === 1'b1) begin
      if (to_q.size() == 0) chk("timeout_unexpected", 1, 0);
      else chk("timeout_cycle", cyc, to_q.pop_front());
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got cycle %0d expected completion", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    vt[0]  = '{50, 0, 0, 0, 0};
    vt[1]  = '{332, 0, 0, 0, 332};
    vt[2]  = '{332, 0, 0, 0, 332};
    vt[3]  = '{332, 0, 0, 0, 332};
    vt[4]  = '{332, 0, 1, 1, 332};
    vt[5]  = '{332, 0, 1, 1, 332};
    vt[6]  = '{332, 100, 1, 1, 332};
    vt[7]  = '{200, 0, 0, 1, 200};
    vt[8]  = '{332, 0, 1, 1, 332};
    vt[9]  = '{332, 150, 0, 1, 332};
    vt[10] = '{100, 0, 0, 1, 100};
    vt[11] = '{332, 0, 1, 1, 332};
    vt[12] = '{250, 0, 0, 1, 250};
    vt[13] = '{280, 0, 0, 0, 280};
    vt[14] = '{300, 0, 0, 0, 300};
    vt[15] = '{370, 0, 0, 0, 370};
    vt[16] = '{332, 0, 0, 0, 332};
    vt[17] = '{332, 0, 1, 1, 332};
    vt[18] = '{371, 0, 0, 1, 371};
    vt[19] = '{332, 0, 1, 1, 332};
    vt[20] = '{299, 0, 0, 1, 299};
    vt[21] = '{332, 0, 1, 1, 332};
    vt[22] = '{500, 0, 0, 0, 0};
    vt[23] = '{332, 0, 0, 0, 332};
    vt[24] = '{332, 0, 0, 0, 332};
    vt[25] = '{332, 0, 0, 0, 332};
    vt[26] = '{332, 0, 1, 1, 332};
    vt[27] = '{332, 150, 0, 1, 332};
    vt[28] = '{450, 0, 0, 0, 0};
    vt[29] = '{332, 0, 0, 0, 332};
    vt[30] = '{332, 0, 0, 0, 332};
    vt[31] = '{332, 0, 0, 0, 332};
    vt[32] = '{332, 0, 1, 1, 332};

    srst      = 1'b1;
    enable    = 1'b0;
    ref_vsync = 1'b0;
    offset    = 20'd0;
    repeat (3) step();
    chk("rst_locked", int'(locked), 0);
    chk("rst_period", int'(period), 0);
    chk("rst_timeout", int'(timeout), 0);
    chk("rst_genlock", int'(genlock), 0);
    srst   = 1'b0;
    enable = 1'b1;
    prev_rise = cyc;

    // Lock, offset, glitches, unlock, boundary periods, edge-at-timeout.
    run_rows(0, 21);

    // Reference loss: timeout, lock dropped, period held.
    to_q.push_back(prev_rise + 374);
    while (cyc < prev_rise + 374) step();
    chk("loss_locked", int'(locked), 0);
    chk("loss_period", int'(period), 332);
    run_rows(22, 27);

    // Enable drop while a 150-clk delay is pending.
    while (cyc < prev_rise + 77) step();
    enable = 1'b0;
    step();
    chk("endrop_locked", int'(locked), 0);
    step();
    chk("endrop_pcnt", int'(dut.pcnt_q), 0);
    while (cyc < prev_rise + 400) step();
    enable = 1'b1;
    run_rows(28, 32);

    // Reset while pending in lock, reference held high through release.
    while (cyc < prev_rise + 332) step();
    offset    = 20'd150;
    ref_vsync = 1'b1;
    prev_rise = cyc;
    while (cyc < prev_rise + 20) step();
    srst = 1'b1;
    step();
    chk("srst_genlock", int'(genlock), 0);
    chk("srst_locked", int'(locked), 0);
    chk("srst_period", int'(period), 0);
    chk("srst_timeout", int'(timeout), 0);
    step();
    step();
    srst = 1'b0;
    t = cyc;
    while (cyc < t + 3) step();
    chk("release_edge_period", int'(period), 2);
    chk("release_locked", int'(locked), 0);
    repeat (300) step();

    chk("genlock_queue_empty", gl_q.size(), 0);
    chk("timeout_queue_empty", to_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
